// File: rtl/afifo_rd_arbiter.sv
// afifo_rd_arbiter: read-side scheduler for NUM_SRC async FIFOs sharing rclk.
// Picks a non-empty FIFO round-robin, holds that grant for a whole packet
// (until a word with the last flag), and registers each popped word into a
// single valid/ready output stage.
//
// Ports:
//   rclk, rrst_n   read-domain clock, asynchronous active-low reset
//   src_rempty     per-FIFO empty flag (1 = no word at head)
//   src_rdata      per-FIFO head word, src i at [i*DATA_W +: DATA_W]
//   src_rinc       per-FIFO pop strobe, at most one bit high
//   m_valid/m_data/m_src/m_ready  merged output stream and its source index
//   busy           high while a multi-beat packet holds the grant
module afifo_rd_arbiter #(
    parameter  int unsigned NUM_SRC  = 4,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned LAST_BIT = 0,
    localparam int unsigned SRC_W    = $clog2(NUM_SRC)
) (
    input  logic                      rclk,
    input  logic                      rrst_n,
    input  logic [NUM_SRC-1:0]        src_rempty,
    input  logic [NUM_SRC*DATA_W-1:0] src_rdata,
    output logic [NUM_SRC-1:0]        src_rinc,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    output logic [SRC_W-1:0]          m_src,
    input  logic                      m_ready,
    output logic                      busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [SRC_W-1:0]    rr_ptr, rr_ptr_next;
    logic [SRC_W-1:0]    lock_src, lock_src_next;
    logic                m_valid_next;
    logic [DATA_W-1:0]   m_data_next;
    logic [SRC_W-1:0]    m_src_next;

    logic [DATA_W-1:0]   src_word [NUM_SRC];
    logic [SRC_W-1:0]    rr_grant;
    logic [SRC_W-1:0]    rr_cand;
    logic                rr_found;
    logic [SRC_W-1:0]    grant;
    logic                grant_ok;
    logic                can_load;
    logic                pop;
    logic                pop_last;

    // Unpack the flat head-word bus
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_word[i] = src_rdata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin scan starting just after rr_ptr; wraps modulo NUM_SRC
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            rr_cand = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
            if (!rr_found && !src_rempty[rr_cand]) begin
                rr_found = 1'b1;
                rr_grant = rr_cand;
            end
        end
    end

    // Grant is locked to lock_src for the rest of a packet
    assign grant    = (state == ST_LOCKED) ? lock_src : rr_grant;
    assign grant_ok = (state == ST_LOCKED) ? !src_rempty[lock_src] : rr_found;
    assign can_load = !m_valid || m_ready;
    assign pop      = can_load && grant_ok;
    assign pop_last = src_word[grant][LAST_BIT];
    assign busy     = (state == ST_LOCKED);

    // Next-state, pop strobe and output-stage update
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        lock_src_next = lock_src;
        m_valid_next  = m_valid;
        m_data_next   = m_data;
        m_src_next    = m_src;
        src_rinc      = '0;

        if (pop) begin
            src_rinc[grant] = 1'b1;
            m_valid_next    = 1'b1;
            m_data_next     = src_word[grant];
            m_src_next      = grant;
            case (state)
                ST_IDLE: begin
                    rr_ptr_next = grant;
                    if (!pop_last) begin
                        state_next    = ST_LOCKED;
                        lock_src_next = grant;
                    end
                end
                ST_LOCKED: begin
                    // rr_ptr already equals lock_src, so the scan resumes after it
                    if (pop_last) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (m_ready) begin
            m_valid_next = 1'b0;
        end
    end

    // State and output-stage registers
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= SRC_W'(NUM_SRC - 1);
            lock_src <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_src    <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            lock_src <= lock_src_next;
            m_valid  <= m_valid_next;
            m_data   <= m_data_next;
            m_src    <= m_src_next;
        end
    end

    a_rinc_onehot: assert property (@(posedge rclk) disable iff (!rrst_n)
        $onehot0(src_rinc));
    a_rinc_not_empty: assert property (@(posedge rclk) disable iff (!rrst_n)
        (src_rinc & src_rempty) == '0);
    a_hold_stable: assert property (@(posedge rclk) disable iff (!rrst_n)
        (m_valid && !m_ready) |=> ($stable(m_data) && $stable(m_src)));

endmodule
